// File: rtl/router_rr_nxm_pkg.sv
// Shared defaults and helpers for the N-in/M-out round-robin router.
package router_rr_nxm_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEST_W  = 2;
  localparam int DEF_NUM_IN  = 4;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int MAX_IN      = 8;

  typedef logic [MAX_IN-1:0] in_vec_t;

  // Number of inputs dropping a word in one cycle; at most MAX_IN.
  function automatic logic [3:0] count_ones(input in_vec_t v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_IN; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/router_rr_nxm_if.sv
// Upstream FIFO heads, downstream push side and error/status of the router.
interface router_rr_nxm_if
  import router_rr_nxm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEST_W  = DEF_DEST_W,
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int CNT_W   = DEF_CNT_W
);

  logic [NUM_IN*(DEST_W+DATA_W)-1:0] in_word;
  logic [NUM_IN-1:0]                 in_empty;
  logic [NUM_IN-1:0]                 pop;
  logic [NUM_OUT-1:0]                out_almost_full;
  logic [NUM_OUT*DATA_W-1:0]         out_data;
  logic [NUM_OUT-1:0]                out_push;
  logic                              err_clr;
  logic [NUM_IN-1:0]                 error;
  logic [CNT_W-1:0]                  drop_count;

  modport master (
    output in_word, in_empty, out_almost_full, err_clr,
    input  pop, out_data, out_push, error, drop_count
  );

  modport slave (
    input  in_word, in_empty, out_almost_full, err_clr,
    output pop, out_data, out_push, error, drop_count
  );

endinterface

// File: rtl/router_rr_nxm_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer wins, wrapping modulo N.
// Pointer moves to winner+1 only when grant_en is high and a grant was made.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         grant_en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic [PW:0]   wide;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    wide  = '0;
    for (int k = 0; k < N; k++) begin
      wide = {1'b0, ptr_q} + (PW+1)'(k);
      if (wide >= (PW+1)'(N)) wide = wide - (PW+1)'(N);
      idx = wide[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant_en && found) begin
      ptr_q <= (gidx == PW'(N-1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/router_rr_nxm.sv
// Routes head words of NUM_IN show-ahead FIFOs to NUM_OUT outputs by dest field, one
// round-robin arbiter per output; invalid destinations are popped, flagged and counted.
module router_rr_nxm
  import router_rr_nxm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEST_W  = DEF_DEST_W,
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic            clk,
  input logic            reset,
  router_rr_nxm_if.slave bus
);

  localparam int WORD_W = DEST_W + DATA_W;
  localparam int SUM_W  = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEST_W-1:0]         dest    [NUM_IN];
  logic [DATA_W-1:0]         payload [NUM_IN];
  logic [NUM_IN-1:0]         drop;
  logic [NUM_IN-1:0]         req     [NUM_OUT];
  logic [NUM_IN-1:0]         grant   [NUM_OUT];
  logic [DATA_W-1:0]         sel     [NUM_OUT];
  logic [NUM_IN-1:0]         pop_c;
  logic [DATA_W-1:0]         data_q  [NUM_OUT];
  logic [NUM_OUT*DATA_W-1:0] data_flat;
  logic [NUM_OUT-1:0]        push_q;
  logic [NUM_IN-1:0]         error_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_next;
  logic [SUM_W-1:0]          cnt_sum;
  logic [MAX_IN-1:0]         drop_ext;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign dest[i]    = bus.in_word[i*WORD_W+DATA_W +: DEST_W];
    assign payload[i] = bus.in_word[i*WORD_W +: DATA_W];
    assign drop[i]    = !bus.in_empty[i] && (int'(dest[i]) >= NUM_OUT);
  end

  // Almost-full masks requests up front so a blocked output never grants or pops.
  always_comb begin
    for (int j = 0; j < NUM_OUT; j++) begin
      req[j] = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        req[j][i] = !bus.in_empty[i] && (int'(dest[i]) == j) && !bus.out_almost_full[j];
      end
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    rr_arbiter #(.N(NUM_IN)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (req[j]),
      .grant_en (!bus.out_almost_full[j]),
      .grant    (grant[j])
    );
  end

  always_comb begin
    pop_c = drop;
    for (int j = 0; j < NUM_OUT; j++) pop_c = pop_c | grant[j];
  end

  assign bus.pop = reset ? '0 : pop_c;

  always_comb begin
    for (int j = 0; j < NUM_OUT; j++) begin
      sel[j] = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant[j][i]) sel[j] = sel[j] | payload[i];
      end
    end
  end

  // Several inputs may drop in the same cycle; the counter saturates rather than wraps.
  always_comb begin
    drop_ext = MAX_IN'(drop);
    cnt_sum  = SUM_W'(cnt_q) + SUM_W'(count_ones(drop_ext));
    cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q  <= '0;
      error_q <= '0;
      cnt_q   <= '0;
      for (int j = 0; j < NUM_OUT; j++) data_q[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        push_q[j] <= |grant[j];
        if (|grant[j]) data_q[j] <= sel[j];
      end
      error_q <= (bus.err_clr ? '0 : error_q) | drop;
      cnt_q   <= cnt_next;
    end
  end

  always_comb begin
    data_flat = '0;
    for (int j = 0; j < NUM_OUT; j++) data_flat[j*DATA_W +: DATA_W] = data_q[j];
  end

  assign bus.out_data   = data_flat;
  assign bus.out_push   = push_q;
  assign bus.error      = error_q;
  assign bus.drop_count = cnt_q;

endmodule

// File: tb/tb_router_rr_nxm.sv
// Bench for router_rr_nxm: a 4x4 build driven from modelled upstream FIFOs with a push
// scoreboard, plus a 4x3 build for invalid-destination handling.
module tb_router_rr_nxm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  router_rr_nxm_if #(.NUM_OUT(4)) b4 ();
  router_rr_nxm_if #(.NUM_OUT(3)) b3 ();

  router_rr_nxm #(.NUM_OUT(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  router_rr_nxm #(.NUM_OUT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] fq  [4][$];
  logic [7:0] sbq [4][$];
  int         mptr [4];
  logic [3:0] last_pop;
  logic [3:0] last_pop3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_in();
    for (int i = 0; i < 4; i++) begin
      b4.in_empty[i]        = (fq[i].size() == 0);
      b4.in_word[i*10 +: 10] = (fq[i].size() > 0) ? fq[i][0] : 10'h000;
    end
  endtask

  // Checks last edge's pushes against the scoreboard, then predicts this cycle's grants.
  task automatic check_cycle();
    logic [3:0] ep;
    logic [7:0] e;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("push%0d", j), 32'(b4.out_push[j]), 32'(sbq[j].size() > 0));
      if (sbq[j].size() > 0) begin
        e = sbq[j].pop_front();
        if (b4.out_push[j]) chk($sformatf("data%0d", j), 32'(b4.out_data[j*8 +: 8]), 32'(e));
      end
    end
    ep = '0;
    if (reset) begin
      for (int j = 0; j < 4; j++) mptr[j] = 0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        int gi;
        gi = -1;
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (mptr[j] + k) % 4;
          if (gi < 0 && fq[i].size() > 0 && int'(fq[i][0][9:8]) == j && !b4.out_almost_full[j])
            gi = i;
        end
        if (gi >= 0) begin
          ep[gi] = 1'b1;
          sbq[j].push_back(fq[gi][0][7:0]);
          mptr[j] = (gi + 1) % 4;
        end
      end
    end
    chk("pop", 32'(b4.pop), 32'(ep));
    last_pop  = b4.pop;
    last_pop3 = b3.pop;
  endtask

  task automatic step();
    drive_in();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (last_pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
  endtask

  initial begin
    logic [3:0] ev;
    reset = 1'b1;
    b4.out_almost_full = '0; b4.err_clr = 1'b0; b4.in_word = '0; b4.in_empty = '1;
    b3.out_almost_full = '0; b3.err_clr = 1'b0; b3.in_word = '0; b3.in_empty = '1;
    for (int j = 0; j < 4; j++) mptr[j] = 0;

    repeat (2) step();
    reset = 1'b0;
    chk("rst_push4", 32'(b4.out_push), 32'h0);
    chk("rst_err4",  32'(b4.error), 32'h0);
    chk("rst_cnt4",  32'(b4.drop_count), 32'h0);
    chk("rst_push3", 32'(b3.out_push), 32'h0);
    chk("rst_data4", 32'(b4.out_data), 32'h0);

    // single flow
    fq[0].push_back({2'd1, 8'hA5});
    step();
    chk("sf_pop",  32'(last_pop), 32'h1);
    chk("sf_push", 32'(b4.out_push), 32'h2);
    chk("sf_data", 32'(b4.out_data[15:8]), 32'hA5);
    step();

    // round robin on output 2
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) fq[i].push_back({2'd2, 8'(i*16 + k)});
    for (int n = 0; n < 5; n++) begin
      step();
      ev = 4'(1 << (n % 4));
      chk("rr_order", 32'(last_pop), 32'(ev));
    end

    // backpressure holds pointer at input 1
    b4.out_almost_full = 4'b0100;
    repeat (3) begin
      step();
      chk("bp_pop",  32'(last_pop), 32'h0);
      chk("bp_push", 32'(b4.out_push[2]), 32'h0);
    end
    b4.out_almost_full = 4'b0000;
    step();
    chk("bp_resume", 32'(last_pop), 32'h2);

    // parallel routing
    for (int i = 0; i < 4; i++) fq[i].delete();
    fq[0].push_back({2'd3, 8'h30});
    fq[3].push_back({2'd0, 8'h03});
    step();
    chk("par_pop",   32'(last_pop), 32'h9);
    chk("par_push",  32'(b4.out_push), 32'h9);
    chk("par_data3", 32'(b4.out_data[31:24]), 32'h30);
    chk("par_data0", 32'(b4.out_data[7:0]), 32'h03);
    step();

    // invalid destination on the 3-output build
    b3.in_word[19:10] = {2'd3, 8'h77};
    b3.in_empty = 4'b1101;
    step();
    chk("inv_pop1",  32'(last_pop3), 32'h2);
    chk("inv_push1", 32'(b3.out_push), 32'h0);
    chk("inv_err1",  32'(b3.error), 32'h2);
    chk("inv_cnt1",  32'(b3.drop_count), 32'h1);
    b3.out_almost_full = 3'b111;
    b3.in_word[19:10] = {2'd3, 8'h78};
    step();
    chk("inv_pop2",  32'(last_pop3), 32'h2);
    chk("inv_push2", 32'(b3.out_push), 32'h0);
    chk("inv_err2",  32'(b3.error), 32'h2);
    chk("inv_cnt2",  32'(b3.drop_count), 32'h2);
    b3.out_almost_full = 3'b000;
    b3.in_empty = 4'b1111;
    b3.err_clr = 1'b1;
    step();
    chk("clr_pop", 32'(last_pop3), 32'h0);
    chk("clr_err", 32'(b3.error), 32'h0);
    chk("clr_cnt", 32'(b3.drop_count), 32'h2);
    b3.in_word[29:20] = {2'd3, 8'h79};
    b3.in_empty = 4'b1001;
    step();
    chk("setwin_pop", 32'(last_pop3), 32'h6);
    chk("setwin_err", 32'(b3.error), 32'h6);
    chk("setwin_cnt", 32'(b3.drop_count), 32'h4);
    chk("setwin_push", 32'(b3.out_push), 32'h0);
    b3.err_clr = 1'b0;
    b3.in_empty = 4'b1111;

    // reset in the middle of traffic
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) fq[i].push_back({2'd2, 8'(8'h80 + i*16 + k)});
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("mrst_pop",   32'(last_pop), 32'h0);
    chk("mrst_push4", 32'(b4.out_push), 32'h0);
    chk("mrst_err3",  32'(b3.error), 32'h0);
    chk("mrst_cnt3",  32'(b3.drop_count), 32'h0);
    step();
    chk("mrst_pop2",  32'(last_pop), 32'h0);
    reset = 1'b0;
    step();
    chk("mrst_first", 32'(last_pop), 32'h1);
    repeat (2) step();
    for (int i = 0; i < 4; i++) fq[i].delete();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
